// File: rtl/crc_arb_pkg.sv
// Shared types for the CRC stream arbiter: FSM state encoding and tag sizing.
package crc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int tag_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/crc_tag_fifo.sv
// In-flight tag FIFO: remembers which requester owns each packet still inside the CRC engine.
module crc_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output logic [TAG_W-1:0]           pop_tag,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a paired push.
    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

    assign pop_tag = mem[rd_ptr];
    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/crc_stream_arbiter.sv
// Round-robin arbiter multiplexing N_REQ AXI-Stream packet sources into one byte-enable
// CRC engine, tagging each packet so the returned CRC is routed back to its owner.
module crc_stream_arbiter
    import crc_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWIDTH       = 512,
    parameter int CRC_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ*DWIDTH-1:0]         s_tdata,
    input  logic [N_REQ*DWIDTH/8-1:0]       s_tkeep,
    input  logic [N_REQ-1:0]                s_tlast,
    input  logic [N_REQ-1:0]                s_tvalid,
    output logic [N_REQ-1:0]                s_tready,
    output logic [DWIDTH-1:0]               eng_din,
    output logic [DWIDTH/8-1:0]             eng_byteEn,
    output logic                            eng_dlast,
    output logic                            eng_flitEn,
    input  logic [CRC_WIDTH-1:0]            eng_crc,
    input  logic                            eng_crc_vld,
    output logic [CRC_WIDTH-1:0]            res_crc,
    output logic [tag_width(N_REQ)-1:0]     res_id,
    output logic                            res_vld,
    output logic                            err_orphan
);

    localparam int TAG_W = tag_width(N_REQ);
    localparam int KW    = DWIDTH / 8;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    arb_state_t       state, state_nxt;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] rr;
    logic [TAG_W-1:0] win_idx;
    logic [TAG_W-1:0] cand;
    logic             win_found;
    logic             grant_now;
    logic             beat_acc;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_tag;
    logic [CNT_W-1:0] fifo_count;

    logic [DWIDTH-1:0] din_p0;
    logic [KW-1:0]     keep_p0;
    logic              last_p0;
    logic              vld_p0;

    logic [CRC_WIDTH-1:0] crc_p1;
    logic [TAG_W-1:0]     id_p1;
    logic                 vld_p1;
    logic                 orphan_p1;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = TAG_W'((int'(rr) + i) % N_REQ);
            if (!win_found && s_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign fifo_pop  = eng_crc_vld & (fifo_count != '0);
    // A result popping this cycle makes room for the new tag, so grant through a full FIFO then.
    assign grant_now = (state == IDLE) & win_found & (~fifo_full | fifo_pop);
    assign beat_acc  = (state == BUSY) & s_tvalid[grant];

    always_comb begin
        state_nxt = state;
        s_tready  = '0;
        case (state)
            IDLE: if (grant_now) state_nxt = BUSY;
            BUSY: begin
                s_tready[grant] = 1'b1;
                if (beat_acc && s_tlast[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                grant <= win_idx;
                rr    <= (win_idx == TAG_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    crc_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant_now),
        .push_tag (win_idx),
        .pop      (fifo_pop),
        .pop_tag  (fifo_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Stage p0: registered beat towards the engine; data holds between accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            din_p0  <= '0;
            keep_p0 <= '0;
        end else begin
            vld_p0 <= beat_acc;
            if (beat_acc) begin
                din_p0  <= s_tdata[int'(grant)*DWIDTH +: DWIDTH];
                keep_p0 <= s_tkeep[int'(grant)*KW +: KW];
                last_p0 <= s_tlast[grant];
            end
        end
    end

    // Stage p1: engine result tagged with the requester popped from the in-flight FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            crc_p1    <= '0;
            id_p1     <= '0;
            orphan_p1 <= 1'b0;
        end else begin
            vld_p1 <= fifo_pop;
            if (fifo_pop) begin
                crc_p1 <= eng_crc;
                id_p1  <= fifo_tag;
            end
            if (eng_crc_vld && fifo_empty) orphan_p1 <= 1'b1;
        end
    end

    assign eng_din    = din_p0;
    assign eng_byteEn = keep_p0;
    assign eng_dlast  = last_p0;
    assign eng_flitEn = vld_p0;
    assign res_crc    = crc_p1;
    assign res_id     = id_p1;
    assign res_vld    = vld_p1;
    assign err_orphan = orphan_p1;

endmodule

// File: tb/tb_crc_stream_arbiter.sv
// Directed bench for crc_stream_arbiter with a behavioural CRC-16/CCITT engine stand-in.
module tb_crc_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int CW = 16;
    localparam int MI = 2;
    localparam int TW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            gap;
    } beat_t;

    typedef struct {
        int          id;
        logic [15:0] crc;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     eng_din;
    logic [KW-1:0]     eng_byteEn;
    logic              eng_dlast;
    logic              eng_flitEn;
    logic [CW-1:0]     eng_crc;
    logic              eng_crc_vld;
    logic [CW-1:0]     res_crc;
    logic [TW-1:0]     res_id;
    logic              res_vld;
    logic              err_orphan;

    int checks = 0;
    int passes = 0;

    beat_t       rq[N][$];
    logic [15:0] gold[N][$];
    logic [15:0] eng_q[$];
    res_t        exp_q[$];
    res_t        got_q[$];
    int          order[$];
    bit          flit_log[$];
    bit          last_log[$];
    logic [15:0] mon_crc = 16'hFFFF;
    logic [KW-1:0] last_keep;
    bit          ret_en = 1'b0;
    int          ret_pulse = 0;

    always #5 clk = ~clk;

    crc_stream_arbiter #(
        .N_REQ(N), .DWIDTH(DW), .CRC_WIDTH(CW), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .eng_din(eng_din), .eng_byteEn(eng_byteEn), .eng_dlast(eng_dlast),
        .eng_flitEn(eng_flitEn), .eng_crc(eng_crc), .eng_crc_vld(eng_crc_vld),
        .res_crc(res_crc), .res_id(res_id), .res_vld(res_vld), .err_orphan(err_orphan)
    );

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        c = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // Most significant keep bit is the first byte on the wire.
    function automatic logic [15:0] crc_beat(input logic [15:0] c, input logic [DW-1:0] d,
                                             input logic [KW-1:0] k);
        for (int j = KW - 1; j >= 0; j--) if (k[j]) c = crc_byte(c, d[j*8 +: 8]);
        return c;
    endfunction

    function automatic logic [31:0] order_word();
        logic [31:0] w = 32'h1;
        foreach (order[i]) w = (w << 4) | 32'(order[i]);
        return w;
    endfunction

    function automatic bit all_sent();
        for (int r = 0; r < N; r++) if (rq[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Engine stand-in: accumulates the CRC of every forwarded beat and collects results.
    always @(negedge clk) begin
        if (rst) begin
            mon_crc = 16'hFFFF;
        end else begin
            if (eng_flitEn) begin
                mon_crc = crc_beat(mon_crc, eng_din, eng_byteEn);
                if (eng_dlast) begin
                    eng_q.push_back(mon_crc);
                    last_keep = eng_byteEn;
                    mon_crc = 16'hFFFF;
                end
            end
            if (res_vld) got_q.push_back('{int'(res_id), res_crc});
        end
    end

    task automatic add_pkt(input int r, input int nb, input logic [7:0] seed,
                           input logic [KW-1:0] klast, input int gap_beat, input int gap_len);
        logic [15:0] c = 16'hFFFF;
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < KW; j++) bt.d[j*8 +: 8] = seed + 8'(b * KW + j);
            bt.k   = (b == nb - 1) ? klast : '1;
            bt.l   = (b == nb - 1);
            bt.gap = (b == gap_beat) ? gap_len : 0;
            c = crc_beat(c, bt.d, bt.k);
            rq[r].push_back(bt);
        end
        gold[r].push_back(c);
    endtask

    task automatic step();
        logic [N-1:0] v = '0;
        logic [N-1:0] acc;
        beat_t bt;
        for (int r = 0; r < N; r++) begin
            if (rq[r].size() != 0) begin
                bt = rq[r][0];
                if (bt.gap == 0) begin
                    v[r] = 1'b1;
                    s_tdata[r*DW +: DW] = bt.d;
                    s_tkeep[r*KW +: KW] = bt.k;
                    s_tlast[r] = bt.l;
                end else begin
                    bt.gap = bt.gap - 1;
                    rq[r][0] = bt;
                end
            end
        end
        s_tvalid = v;
        if ((ret_en || ret_pulse > 0) && eng_q.size() != 0) begin
            eng_crc = eng_q.pop_front();
            eng_crc_vld = 1'b1;
            if (ret_pulse > 0) ret_pulse--;
        end else begin
            eng_crc_vld = 1'b0;
        end
        acc = v & s_tready;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                if (rq[r][0].l) begin
                    order.push_back(r);
                    exp_q.push_back('{r, gold[r].pop_front()});
                end
                void'(rq[r].pop_front());
            end
        end
        flit_log.push_back(eng_flitEn);
        last_log.push_back(eng_flitEn & eng_dlast);
        eng_crc_vld = 1'b0;
    endtask

    task automatic run_drain(input string name, input int maxc);
        int n = 0;
        ret_en = 1'b1;
        while (!(all_sent() && eng_q.size() == 0 && got_q.size() >= exp_q.size()) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            $display("FAIL %s_timeout: still busy after %0d cycles, results got %0d required %0d",
                     name, n, got_q.size(), exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        s_tkeep = '0;
        eng_crc = '0;
        eng_crc_vld = 1'b0;
        ret_en = 1'b0;
        ret_pulse = 0;
        repeat (2) begin @(posedge clk); #1; end
        for (int r = 0; r < N; r++) begin rq[r].delete(); gold[r].delete(); end
        eng_q.delete(); exp_q.delete(); got_q.delete(); order.delete();
        flit_log.delete(); last_log.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = '1;
        s_tlast = '1;
        s_tdata = '1;
        s_tkeep = '1;
        eng_crc = 16'h1234;
        eng_crc_vld = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({s_tready, eng_flitEn, eng_dlast, res_vld, err_orphan} !== 8'h00)
            $display("FAIL reset_ctrl: tready/flit/dlast/resvld/orphan=%b required 00000000",
                     {s_tready, eng_flitEn, eng_dlast, res_vld, err_orphan});
        else passes++;
        checks++;
        if (eng_din !== '0 || eng_byteEn !== '0)
            $display("FAIL reset_eng_data: din=%h byteEn=%h required 0/0", eng_din, eng_byteEn);
        else passes++;
        checks++;
        if (res_crc !== '0 || res_id !== '0)
            $display("FAIL reset_result: res_crc=%h res_id=%0d required 0/0", res_crc, res_id);
        else passes++;
        do_reset();
    endtask

    task automatic test_single_packet();
        logic [4:0] fw, lw;
        int pulses = 0;
        do_reset();
        add_pkt(0, 3, 8'h10, '1, -1, 0);
        run_drain("single", 40);
        for (int i = 0; i < 5; i++) begin
            fw[4-i] = (i < flit_log.size()) ? flit_log[i] : 1'b0;
            lw[4-i] = (i < last_log.size()) ? last_log[i] : 1'b0;
        end
        foreach (flit_log[i]) pulses += int'(flit_log[i]);
        checks++;
        if (fw !== 5'b01110) $display("FAIL single_flit_pattern: got %b required 01110", fw);
        else passes++;
        checks++;
        if (lw !== 5'b00010) $display("FAIL single_dlast_pattern: got %b required 00010", lw);
        else passes++;
        checks++;
        if (pulses !== 3) $display("FAIL single_flit_count: got %0d required 3", pulses);
        else passes++;
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1)
            $display("FAIL single_result: got %0d results required 1", got_q.size());
        else if (got_q[0].id !== 0 || got_q[0].crc !== exp_q[0].crc)
            $display("FAIL single_result: id=%0d crc=%h required id=0 crc=%h",
                     got_q[0].id, got_q[0].crc, exp_q[0].crc);
        else passes++;
    endtask

    task automatic test_round_robin();
        do_reset();
        add_pkt(0, 1, 8'h20, '1, -1, 0);
        add_pkt(0, 1, 8'h24, '1, -1, 0);
        add_pkt(1, 1, 8'h21, '1, -1, 0);
        add_pkt(2, 1, 8'h22, '1, -1, 0);
        add_pkt(3, 1, 8'h23, '1, -1, 0);
        run_drain("rr", 80);
        checks++;
        if (order_word() !== 32'h101230)
            $display("FAIL rr_grant_order: got %h required 00101230", order_word());
        else passes++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size())
                $display("FAIL rr_result[%0d]: missing, required id=%0d crc=%h", i, exp_q[i].id, exp_q[i].crc);
            else if (got_q[i].id !== exp_q[i].id || got_q[i].crc !== exp_q[i].crc)
                $display("FAIL rr_result[%0d]: id=%0d crc=%h required id=%0d crc=%h",
                         i, got_q[i].id, got_q[i].crc, exp_q[i].id, exp_q[i].crc);
            else passes++;
        end
    endtask

    task automatic test_rr_pointer();
        exp_q.delete(); got_q.delete(); order.delete();
        add_pkt(0, 1, 8'h30, '1, -1, 0);
        add_pkt(2, 1, 8'h32, '1, -1, 0);
        run_drain("rr_ptr", 40);
        checks++;
        if (order_word() !== 32'h120)
            $display("FAIL rr_pointer_order: got %h required 00000120", order_word());
        else passes++;
    endtask

    task automatic test_gap();
        int pos[$];
        logic [15:0] gapless_crc;
        do_reset();
        add_pkt(2, 3, 8'h40, '1, -1, 0);
        run_drain("gapless", 40);
        gapless_crc = (got_q.size() != 0) ? got_q[0].crc : 16'hxxxx;
        exp_q.delete(); got_q.delete(); order.delete(); flit_log.delete(); last_log.delete();
        add_pkt(2, 3, 8'h40, '1, 1, 5);
        run_drain("gap", 60);
        foreach (flit_log[i]) if (flit_log[i]) pos.push_back(i);
        checks++;
        if (pos.size() != 3)
            $display("FAIL gap_flit_count: got %0d required 3", pos.size());
        else if (pos[1] - pos[0] - 1 != 5 || pos[2] - pos[1] - 1 != 0)
            $display("FAIL gap_idle_cycles: got %0d,%0d required 5,0",
                     pos[1] - pos[0] - 1, pos[2] - pos[1] - 1);
        else passes++;
        checks++;
        if (got_q.size() != 1 || got_q[0].crc !== gapless_crc || got_q[0].crc !== exp_q[0].crc)
            $display("FAIL gap_crc: got %0d results, crc=%h required %h (gapless %h)", got_q.size(),
                     (got_q.size() != 0) ? got_q[0].crc : 16'h0, exp_q[0].crc, gapless_crc);
        else passes++;
    endtask

    task automatic test_inflight_limit();
        do_reset();
        add_pkt(0, 1, 8'h50, '1, -1, 0);
        add_pkt(1, 1, 8'h51, '1, -1, 0);
        add_pkt(3, 1, 8'h53, '1, -1, 0);
        repeat (12) step();
        checks++;
        if (order_word() !== 32'h101 || rq[3].size() != 1)
            $display("FAIL inflight_block: order=%h pending3=%0d required 00000101/1",
                     order_word(), rq[3].size());
        else passes++;
        checks++;
        if (got_q.size() != 0) $display("FAIL inflight_no_result: got %0d required 0", got_q.size());
        else passes++;
        ret_pulse = 1;
        step();
        checks++;
        if (s_tready !== 4'b1000)
            $display("FAIL inflight_push_pop_grant: s_tready=%b required 1000", s_tready);
        else passes++;
        repeat (4) step();
        checks++;
        if (order_word() !== 32'h1013 || got_q.size() != 1 || got_q[0].id !== 0 || got_q[0].crc !== exp_q[0].crc)
            $display("FAIL inflight_first_return: order=%h results=%0d required 00001013/1 id0 crc %h",
                     order_word(), got_q.size(), exp_q[0].crc);
        else passes++;
        add_pkt(0, 1, 8'h54, '1, -1, 0);
        repeat (10) step();
        checks++;
        if (order_word() !== 32'h1013)
            $display("FAIL inflight_still_full: order=%h required 00001013", order_word());
        else passes++;
        run_drain("inflight", 60);
        checks++;
        if (order_word() !== 32'h10130)
            $display("FAIL inflight_final_order: order=%h required 00010130", order_word());
        else passes++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size())
                $display("FAIL inflight_result[%0d]: missing, required id=%0d", i, exp_q[i].id);
            else if (got_q[i].id !== exp_q[i].id || got_q[i].crc !== exp_q[i].crc)
                $display("FAIL inflight_result[%0d]: id=%0d crc=%h required id=%0d crc=%h",
                         i, got_q[i].id, got_q[i].crc, exp_q[i].id, exp_q[i].crc);
            else passes++;
        end
    endtask

    task automatic test_partial_keep();
        do_reset();
        add_pkt(1, 2, 8'h80, 16'hFF00, -1, 0);
        run_drain("keep", 40);
        checks++;
        if (last_keep !== 16'hFF00) $display("FAIL keep_byteEn: got %h required ff00", last_keep);
        else passes++;
        checks++;
        if (got_q.size() != 1 || got_q[0].id !== 1 || got_q[0].crc !== exp_q[0].crc)
            $display("FAIL keep_crc: results=%0d crc=%h required id=1 crc=%h", got_q.size(),
                     (got_q.size() != 0) ? got_q[0].crc : 16'h0, exp_q[0].crc);
        else passes++;
    endtask

    task automatic test_reset_orphan();
        checks++;
        if (err_orphan !== 1'b0) $display("FAIL orphan_before: got %b required 0", err_orphan);
        else passes++;
        do_reset();
        add_pkt(0, 3, 8'h90, '1, -1, 0);
        repeat (2) step();
        checks++;
        if (eng_flitEn !== 1'b1) $display("FAIL midpkt_flit: got %b required 1", eng_flitEn);
        else passes++;
        rst = 1'b1;
        s_tvalid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < N; r++) begin rq[r].delete(); gold[r].delete(); end
        eng_q.delete(); got_q.delete(); exp_q.delete();
        eng_crc = 16'hBEEF;
        eng_crc_vld = 1'b1;
        @(posedge clk); #1;
        eng_crc_vld = 1'b0;
        checks++;
        if ({s_tready, eng_flitEn, eng_dlast, res_vld} !== 7'h00)
            $display("FAIL orphan_ctrl: tready/flit/dlast/resvld=%b required 0000000",
                     {s_tready, eng_flitEn, eng_dlast, res_vld});
        else passes++;
        checks++;
        if (eng_din !== '0 || eng_byteEn !== '0 || res_crc !== '0 || res_id !== '0)
            $display("FAIL orphan_data: din=%h byteEn=%h res_crc=%h res_id=%0d required all 0",
                     eng_din, eng_byteEn, res_crc, res_id);
        else passes++;
        checks++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_flag: got %b required 1", err_orphan);
        else passes++;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (err_orphan !== 1'b1 || got_q.size() != 0)
            $display("FAIL orphan_sticky: flag=%b results=%0d required 1/0", err_orphan, got_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_rr_pointer();
        test_gap();
        test_inflight_limit();
        test_partial_keep();
        test_reset_orphan();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/crc_stream_arbiter.md
CRC_STREAM_ARBITER -- requirements
Module: crc_stream_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of AXI-Stream requesters sharing one CRC engine (2..16).
REQ-002 Parameter DWIDTH, 512, data beat width in bits (multiple of 8, >8).
REQ-003 Parameter CRC_WIDTH, 16, CRC result width.
REQ-004 Parameter MAX_INFLIGHT, 8, max packets granted but not yet returned by the engine (power of 2).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_tdata  input  N_REQ*DWIDTH  requester data, slice i = requester i.
REQ-008 s_tkeep  input  N_REQ*DWIDTH/8  requester byte enables; bit DWIDTH/8-1 = first byte on wire.
REQ-009 s_tlast  input  N_REQ  end-of-packet per requester.
REQ-010 s_tvalid  input  N_REQ  beat valid per requester.
REQ-011 s_tready  output  N_REQ  beat accepted per requester.
REQ-012 eng_din  output  DWIDTH  to engine din.
REQ-013 eng_byteEn  output  DWIDTH/8  to engine byteEn.
REQ-014 eng_dlast  output  1  to engine dlast.
REQ-015 eng_flitEn  output  1  to engine flitEn.
REQ-016 eng_crc  input  CRC_WIDTH  engine crc_out.
REQ-017 eng_crc_vld  input  1  engine crc_out_vld.
REQ-018 res_crc  output  CRC_WIDTH  returned CRC.
REQ-019 res_id  output  clog2(N_REQ)  requester index owning res_crc.
REQ-020 res_vld  output  1  single-cycle result strobe; no backpressure.
REQ-021 err_orphan  output  1  sticky: eng_crc_vld seen with no packet in flight.

Function
REQ-022 FSM states IDLE, BUSY; IDLE->BUSY when any s_tvalid set and in-flight count < MAX_INFLIGHT; BUSY->IDLE on accepted beat with s_tlast.
REQ-023 Grant is round-robin from pointer rr; first set s_tvalid at index >= rr (wrapping) wins; rr <= winner+1 mod N_REQ at grant.
REQ-024 Grant is registered; s_tready[g] asserted only in BUSY for granted g; all other s_tready low; packets never interleave.
REQ-025 Accepted beat = s_tvalid[g] & s_tready[g]; at cycle t, eng_flitEn=1 at t+1 with eng_din/eng_byteEn/eng_dlast registered copies of slice g.
REQ-026 Non-accepted cycles: eng_flitEn=0; eng_din/eng_byteEn/eng_dlast hold; requester gaps mid-packet allowed.
REQ-027 Beat after tlast: one IDLE cycle minimum, so back-to-back packets yield one empty engine cycle.
REQ-028 At grant, g pushed into in-flight tag FIFO (depth MAX_INFLIGHT); grant never issued when FIFO full.
REQ-029 On eng_crc_vld: pop FIFO; at next cycle res_vld=1, res_crc=eng_crc, res_id=popped tag.
REQ-030 Simultaneous push and pop in one cycle: count unchanged, both succeed, including when full.
REQ-031 eng_crc_vld with FIFO empty: no pop, no res_vld, err_orphan <= 1 until rst.
REQ-032 s_tkeep forwarded unchanged; contiguity from first byte is the requester's obligation, not checked.

Reset
REQ-033 On rst: state IDLE, rr=0, FIFO empty, count 0, s_tready=0, eng_flitEn=0, eng_dlast=0, eng_din=0, eng_byteEn=0, res_vld=0, res_crc=0, res_id=0, err_orphan=0.
REQ-034 rst mid-packet abandons the packet; the engine shares the same rst, so no stale result returns.

Structure
REQ-035 Package crc_arb_pkg holds the FSM state enum and the tag width function clog2(N_REQ).
REQ-036 Sub-module crc_tag_fifo: synchronous FIFO, width clog2(N_REQ), depth MAX_INFLIGHT, push/pop/full/empty/count.
REQ-037 Engine not instantiated here; the top level connects eng_* to the byte-enable CRC generator.

Verification
REQ-038 Single requester 0, 3-beat packet, all keep ones -> three eng_flitEn pulses, dlast on third; res_vld with res_id=0 and CRC equal to the golden model.
REQ-039 Requesters 0..3 valid simultaneously, rr=0 -> grant order 0,1,2,3; second round from rr=0 again.
REQ-040 Requester 2 drops tvalid for 5 cycles mid-packet -> eng_flitEn low for exactly those 5 cycles; CRC unchanged vs gapless.
REQ-041 MAX_INFLIGHT=2, engine results held off -> third grant blocked until eng_crc_vld; push and pop in the same cycle keeps count=2.
REQ-042 Last beat tkeep=0xFF00..00 (8 bytes) -> eng_byteEn identical; CRC matches the 8-byte-tail golden model.
REQ-043 rst asserted mid-packet, then eng_crc_vld injected -> all outputs at reset values, err_orphan=1.
